booth_mult_unit: RTL and testbench

Sequential signed multiplier for the processor ALU's multiply path. It uses radix-2 Booth recoding and performs one add/subtract-and-shift step per clock. Each step goes through a single carry-lookahead adder built from the existing 8-bit CLA blocks, so a multiply never needs a combinational array. The register-file writeback and stall logic consume its result, overflow flag and one-cycle ready strobe.

---
 rtl/booth_mult_unit_pkg.sv | 22 ++
 rtl/booth_mult_unit_cla_adder_w.sv | 89 ++++++++
 rtl/booth_mult_unit.sv | 141 ++++++++++++++
 tb/tb_booth_mult_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_unit_pkg.sv
// booth_mult_unit_pkg
// Shared ALU definitions for the Booth multiply path.
//   state_t       : multiplier FSM encoding (IDLE / RUN / DONE)
//   BOOTH_*       : radix-2 Booth recode values of {PL[0], q_m1}
//   CLA_BLOCK     : width of one carry-lookahead building block
package booth_mult_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // {current multiplier bit, previous multiplier bit}
  localparam logic [1:0] BOOTH_NOP_LO = 2'b00;
  localparam logic [1:0] BOOTH_ADD    = 2'b01;
  localparam logic [1:0] BOOTH_SUB    = 2'b10;
  localparam logic [1:0] BOOTH_NOP_HI = 2'b11;

  localparam int CLA_BLOCK = 8;

endpackage

// File: rtl/booth_mult_unit_cla_adder_w.sv
// cla_block8 / cla_adder_w
// cla_block8 : 8-bit carry-lookahead block with block generate/propagate.
//   a, b  (in, 8) operands      cin (in, 1) carry in
//   sum   (out, 8) sum          bg, bp (out, 1) block generate / propagate
// cla_adder_w: WIDTH+1-bit adder with carry-in, carry-out discarded.
//   a, b  (in, WIDTH+1) operands  cin (in, 1) carry in
//   sum   (out, WIDTH+1) sum
import booth_mult_unit_pkg::*;

module cla_block8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       bg,
  output logic       bp
);

  logic [7:0] g;
  logic [7:0] p;
  logic [7:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each internal carry is the flattened sum-of-products of earlier
  // generates and the carry-in, so no carry ripples inside the block.
  always_comb begin
    logic term;
    c    = '0;
    bg   = 1'b0;
    term = 1'b0;
    c[0] = cin;
    for (int i = 1; i < 8; i++) begin
      term = cin;
      for (int k = 0; k < i; k++) term = term & p[k];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
    for (int j = 0; j < 8; j++) begin
      term = g[j];
      for (int k = j + 1; k < 8; k++) term = term & p[k];
      bg = bg | term;
    end
  end

  assign bp  = &p;
  assign sum = p ^ c;

endmodule

module cla_adder_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           cin,
  output logic [WIDTH:0] sum
);

  localparam int NBLK = WIDTH / CLA_BLOCK;

  logic [NBLK:0]   bc;
  logic [NBLK-1:0] bg;
  logic [NBLK-1:0] bp;

  assign bc[0] = cin;

  // Blocks are chained through their group generate/propagate terms.
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    cla_block8 u_blk (
      .a   (a[k*CLA_BLOCK +: CLA_BLOCK]),
      .b   (b[k*CLA_BLOCK +: CLA_BLOCK]),
      .cin (bc[k]),
      .sum (sum[k*CLA_BLOCK +: CLA_BLOCK]),
      .bg  (bg[k]),
      .bp  (bp[k])
    );
    assign bc[k+1] = bg[k] | (bp[k] & bc[k]);
  end

  // Guard bit: a single full adder whose carry-out is dropped.
  assign sum[WIDTH] = a[WIDTH] ^ b[WIDTH] ^ bc[NBLK];

endmodule

// File: rtl/booth_mult_unit.sv
// booth_mult_unit
// Sequential radix-2 Booth signed multiplier, one add/sub-and-shift per clock.
//   clock, reset     : clock and synchronous active-high reset
//   ctrl_MULT        : start strobe; operands sampled whenever it is high
//   data_operandA/B  : multiplicand / multiplier, two's complement
//   data_result      : low WIDTH bits of the signed product
//   data_exception   : product does not fit in WIDTH signed bits
//   data_resultRDY   : one-cycle strobe when a new result is presented
// WIDTH must be a multiple of 8 and at least 8.
import booth_mult_unit_pkg::*;

module booth_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] pl;
  logic             q_m1;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   addend;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] pl_sh;
  logic             finish;

  // Booth recode: subtraction is ~M with carry-in 1 through the same adder,
  // so there is only one WIDTH+1-bit adder on the step path.
  always_comb begin
    m_ext   = {m[WIDTH-1], m};
    addend  = '0;
    add_cin = 1'b0;
    case ({pl[0], q_m1})
      BOOTH_ADD: addend = m_ext;
      BOOTH_SUB: begin
        addend  = ~m_ext;
        add_cin = 1'b1;
      end
      BOOTH_NOP_LO, BOOTH_NOP_HI: addend = '0;
      default: addend = '0;
    endcase
  end

  cla_adder_w #(.WIDTH(WIDTH)) u_adder (
    .a   (acc),
    .b   (addend),
    .cin (add_cin),
    .sum (sum)
  );

  // Arithmetic right shift of {ACC', PL, q_m1}; the guard bit replicates.
  assign acc_sh = {sum[WIDTH], sum[WIDTH:1]};
  assign pl_sh  = {sum[0], pl[WIDTH-1:1]};

  // Next state; a start strobe overrides everything, including a finishing
  // step, so an aborted operation never raises the ready strobe.
  always_comb begin
    state_next = state;
    finish     = 1'b0;
    case (state)
      IDLE: state_next = IDLE;
      RUN: begin
        if (cnt == LAST_STEP) begin
          state_next = DONE;
          finish     = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (ctrl_MULT) begin
      state_next = RUN;
      finish     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Multiplier datapath: load on start, one Booth step per RUN cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      m    <= '0;
      acc  <= '0;
      pl   <= '0;
      q_m1 <= 1'b0;
      cnt  <= '0;
    end else if (ctrl_MULT) begin
      m    <= data_operandA;
      acc  <= '0;
      pl   <= data_operandB;
      q_m1 <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      acc  <= acc_sh;
      pl   <= pl_sh;
      q_m1 <= pl[0];
      cnt  <= cnt + 1'b1;
    end
  end

  // Result registers only change on a finishing step; the product fits
  // exactly when the upper half is a pure sign extension of the lower half.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= finish;
      if (finish) begin
        data_result    <= pl_sh;
        data_exception <= (acc_sh[WIDTH-1:0] != {WIDTH{pl_sh[WIDTH-1]}});
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_unit.sv
// tb_booth_mult_unit
// Self-checking bench for booth_mult_unit (WIDTH=32): a constant vector
// table, randomized operands against a 64-bit arithmetic reference, and
// hand-written sequences for back-to-back, abort and reset cases.
module tb_booth_mult_unit;

  localparam int WIDTH    = 32;
  localparam int MAX_WAIT = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
  } vec_t;

  vec_t vecs [10];

  always #5 clock = ~clock;

  booth_mult_unit #(.WIDTH(WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  // Reference: full signed product with plain 64-bit arithmetic.
  function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
    longint sa, sb, p, lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    r  = p[31:0];
    lo = longint'($signed(r));
    e  = (p != lo);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  // Strobes ctrl_MULT across exactly one rising edge (the load edge), then
  // scrambles the operands since they are don't-care afterwards.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    stepClock();
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Edges after the load edge until RDY is seen; 0 if it never arrives.
  task automatic waitRdy(output int lat);
    lat = 0;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      stepClock();
      if (data_resultRDY === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // Counts every RDY pulse over a fixed window, remembering the first one.
  task automatic countRdy(output int n, output int first);
    n = 0;
    first = 0;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      stepClock();
      if (data_resultRDY === 1'b1) begin
        n++;
        if (first == 0) first = k;
      end
    end
  endtask

  task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic e);
    int lat;
    applyStimulus(a, b);
    waitRdy(lat);
    checkOutput({name, " latency"}, 64'(lat), 64'(WIDTH));
    checkOutput({name, " result"}, 64'(data_result), 64'(r));
    checkOutput({name, " exception"}, 64'(data_exception), 64'(e));
    stepClock();
    checkOutput({name, " rdy low after"}, 64'(data_resultRDY), 64'd0);
    checkOutput({name, " result held"}, 64'(data_result), 64'(r));
  endtask

  initial begin
    int          lat;
    int          n;
    int          first;
    int          rdy_seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rr;
    logic        re;

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    vecs[0] = '{a: 32'd3,          b: 32'd5,          r: 32'd15,         e: 1'b0};
    vecs[1] = '{a: 32'hFFFFFFF9,   b: 32'd6,          r: 32'hFFFFFFD6,   e: 1'b0};
    vecs[2] = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   r: 32'h80000000,   e: 1'b1};
    vecs[3] = '{a: 32'h80000000,   b: 32'h80000000,   r: 32'h00000000,   e: 1'b1};
    vecs[4] = '{a: 32'h00010000,   b: 32'h00010000,   r: 32'h00000000,   e: 1'b1};
    vecs[5] = '{a: 32'h00007FFF,   b: 32'h00007FFF,   r: 32'h3FFF0001,   e: 1'b0};
    vecs[6] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   r: 32'h00000001,   e: 1'b0};
    vecs[7] = '{a: 32'h7FFFFFFF,   b: 32'd2,          r: 32'hFFFFFFFE,   e: 1'b1};
    vecs[8] = '{a: 32'h00000000,   b: 32'hDEADBEEF,   r: 32'h00000000,   e: 1'b0};
    vecs[9] = '{a: 32'h80000000,   b: 32'd1,          r: 32'h80000000,   e: 1'b0};

    repeat (3) stepClock();
    checkOutput("reset result", 64'(data_result), 64'd0);
    checkOutput("reset exception", 64'(data_exception), 64'd0);
    checkOutput("reset rdy", 64'(data_resultRDY), 64'd0);
    reset = 1'b0;
    stepClock();

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e);
    end

    $display("[TB] random operands");
    for (int i = 0; i < 16; i++) begin
      ra = (i % 5 == 0) ? 32'h80000000 : 32'($urandom);
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
      refModel(ra, rb, rr, re);
      runOp($sformatf("rand%0d", i), ra, rb, rr, re);
    end

    $display("[TB] back-to-back start in the RDY cycle");
    applyStimulus(32'd6, 32'd7);
    waitRdy(lat);
    checkOutput("b2b first latency", 64'(lat), 64'(WIDTH));
    checkOutput("b2b first result", 64'(data_result), 64'd42);
    applyStimulus(32'hFFFFFFFE, 32'd9);
    checkOutput("b2b rdy drops after reload", 64'(data_resultRDY), 64'd0);
    waitRdy(lat);
    checkOutput("b2b second latency", 64'(lat), 64'(WIDTH));
    checkOutput("b2b second result", 64'(data_result), 64'hFFFFFFEE);
    checkOutput("b2b second exception", 64'(data_exception), 64'd0);

    $display("[TB] abort and reload at E10");
    applyStimulus(32'd3, 32'd5);
    rdy_seen = 0;
    for (int k = 1; k <= 9; k++) begin
      stepClock();
      if (data_resultRDY === 1'b1) rdy_seen++;
    end
    checkOutput("abort no early rdy", 64'(rdy_seen), 64'd0);
    checkOutput("abort old result held", 64'(data_result), 64'hFFFFFFEE);
    applyStimulus(32'd2, 32'd2);
    countRdy(n, first);
    checkOutput("abort rdy count", 64'(n), 64'd1);
    checkOutput("abort rdy latency", 64'(first), 64'(WIDTH));
    checkOutput("abort result", 64'(data_result), 64'd4);

    $display("[TB] reset during RUN");
    runOp("pre-reset", 32'h7FFFFFFF, 32'd3, 32'h7FFFFFFD, 1'b1);
    applyStimulus(32'h00001234, 32'h00005678);
    repeat (4) stepClock();
    reset = 1'b1;
    stepClock();
    reset = 1'b0;
    checkOutput("midrun reset result", 64'(data_result), 64'd0);
    checkOutput("midrun reset exception", 64'(data_exception), 64'd0);
    checkOutput("midrun reset rdy", 64'(data_resultRDY), 64'd0);
    countRdy(n, first);
    checkOutput("midrun reset no rdy", 64'(n), 64'd0);
    checkOutput("midrun reset result stays", 64'(data_result), 64'd0);

    $display("[TB] reset together with start");
    runOp("pre-collide", 32'd5, 32'd5, 32'd25, 1'b0);
    reset         = 1'b1;
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd5;
    stepClock();
    reset     = 1'b0;
    ctrl_MULT = 1'b0;
    checkOutput("collide result cleared", 64'(data_result), 64'd0);
    countRdy(n, first);
    checkOutput("collide no rdy", 64'(n), 64'd0);

    runOp("final", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
